// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: sequencing controller for the E-stage multiply/divide unit.
// Accepts one MD command per cycle, holds the unit busy for a fixed number
// of cycles per operation, owns HI/LO and raises the MD stall for D stage.
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_start,
  input  logic [2:0]  E_md_op,
  input  logic [31:0] E_src_a,
  input  logic [31:0] E_src_b,
  input  logic        D_md_use,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic [2:0]  op_reg, op_next;
  logic [31:0] a_reg, a_next;
  logic [31:0] b_reg, b_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;

  logic        start_multi;
  logic        op_is_mult;
  logic        op_is_signed;
  logic [63:0] prod_signed;
  logic [63:0] prod_unsigned;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] div_n;
  logic [31:0] div_d;
  logic [31:0] quot_raw;
  logic [31:0] rem_raw;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  // A multi-cycle command is being offered by E stage this cycle.
  assign start_multi = E_start && (E_md_op >= OP_MULT) && (E_md_op <= OP_DIVU);

  // Result datapath, evaluated from the latched operands; only committed at
  // the final count edge so the operands must stay frozen while busy.
  assign op_is_mult   = (op_reg == OP_MULT) || (op_reg == OP_MULTU);
  assign op_is_signed = (op_reg == OP_MULT) || (op_reg == OP_DIV);

  assign prod_signed   = $signed({{32{a_reg[31]}}, a_reg}) * $signed({{32{b_reg[31]}}, b_reg});
  assign prod_unsigned = {32'd0, a_reg} * {32'd0, b_reg};

  // Signed divide runs on magnitudes and then fixes signs; this also makes
  // 0x80000000 / -1 wrap to 0x80000000 without relying on tool overflow.
  assign a_mag    = a_reg[31] ? (32'd0 - a_reg) : a_reg;
  assign b_mag    = b_reg[31] ? (32'd0 - b_reg) : b_reg;
  assign div_n    = (op_reg == OP_DIV) ? a_mag : a_reg;
  assign div_d    = (op_reg == OP_DIV) ? b_mag : b_reg;
  assign quot_raw = (div_d == 32'd0) ? 32'd0 : (div_n / div_d);
  assign rem_raw  = (div_d == 32'd0) ? 32'd0 : (div_n % div_d);
  assign quot_fix = ((op_reg == OP_DIV) && (a_reg[31] ^ b_reg[31])) ? (32'd0 - quot_raw) : quot_raw;
  assign rem_fix  = ((op_reg == OP_DIV) && a_reg[31]) ? (32'd0 - rem_raw) : rem_raw;

  // State register; reset aborts any in-flight operation with no HI/LO write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 5'd0;
      op_reg    <= 3'd0;
      a_reg     <= 32'd0;
      b_reg     <= 32'd0;
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  // Next-state: accept commands in IDLE, count down in BUSY, commit on the last count.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    case (state_reg)
      IDLE: begin
        if (E_start) begin
          if (start_multi) begin
            state_next = BUSY;
            op_next    = E_md_op;
            a_next     = E_src_a;
            b_next     = E_src_b;
            cnt_next   = ((E_md_op == OP_MULT) || (E_md_op == OP_MULTU)) ? MULT_LOAD : DIV_LOAD;
          end else if (E_md_op == OP_MTHI) begin
            hi_next = E_src_a;
          end else if (E_md_op == OP_MTLO) begin
            lo_next = E_src_a;
          end
        end
      end
      BUSY: begin
        // Commands arriving here are ignored; D is held by stall_md.
        cnt_next = cnt_reg - 5'd1;
        if (cnt_reg == 5'd1) begin
          state_next = IDLE;
          cnt_next   = 5'd0;
          if (op_is_mult) begin
            {hi_next, lo_next} = op_is_signed ? prod_signed : prod_unsigned;
          end else if (b_reg != 32'd0) begin
            hi_next = rem_fix;
            lo_next = quot_fix;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 5'd0;
      end
    endcase
  end

  assign busy     = (state_reg == BUSY);
  assign stall_md = D_md_use && (busy || start_multi);
  assign hi       = hi_reg;
  assign lo       = lo_reg;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl: directed plan plus randomized commands, checked every
// cycle against a behavioural model of HI/LO, busy duration and stall.
module tb_md_unit_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        E_start;
  logic [2:0]  E_md_op;
  logic [31:0] E_src_a;
  logic [31:0] E_src_b;
  logic        D_md_use;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  int compared   = 0;
  int mismatched = 0;

  md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .E_start  (E_start),
    .E_md_op  (E_md_op),
    .E_src_a  (E_src_a),
    .E_src_b  (E_src_b),
    .D_md_use (D_md_use),
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Result as {valid, hi, lo}; valid=0 means HI/LO are left untouched.
  function automatic logic [64:0] md_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    md_result = 65'd0;
    case (op)
      3'd1: begin p = sa * sb; md_result = {1'b1, p}; end
      3'd2: begin p = ua * ub; md_result = {1'b1, p}; end
      3'd3: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        md_result = {1'b1, r[31:0], q[31:0]};
      end
      3'd4: if (b != 0) md_result = {1'b1, a % b, a / b};
      default: md_result = 65'd0;
    endcase
  endfunction

  int          m_rem = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic [64:0] m_pend = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rem  <= 0;
      m_hi   <= 0;
      m_lo   <= 0;
      m_pend <= 0;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1 && m_pend[64]) begin
        m_hi <= m_pend[63:32];
        m_lo <= m_pend[31:0];
      end
    end else if (E_start) begin
      if (E_md_op >= 1 && E_md_op <= 4) begin
        m_rem  <= (E_md_op <= 2) ? 5 : 10;
        m_pend <= md_result(E_md_op, E_src_a, E_src_b);
      end else if (E_md_op == 5) begin
        m_hi <= E_src_a;
      end else if (E_md_op == 6) begin
        m_lo <= E_src_a;
      end
    end
  end

  // Per-cycle compare, mid-cycle so inputs and outputs are settled.
  always @(negedge clk) begin
    if (!reset) begin
      check("busy", {31'd0, busy}, {31'd0, m_rem > 0});
      check("stall_md", {31'd0, stall_md},
            {31'd0, D_md_use && ((m_rem > 0) || (E_start && E_md_op >= 1 && E_md_op <= 4))});
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Issue one command for one cycle, then watch 15 cycles counting busy/stall.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int busy_n, output int stall_n);
    @(posedge clk); #1;
    E_start = 1'b1; E_md_op = op; E_src_a = a; E_src_b = b;
    @(negedge clk);
    busy_n  = 0;
    stall_n = stall_md ? 1 : 0;
    @(posedge clk); #1;
    E_start = 1'b0; E_md_op = 3'd0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (stall_md) stall_n++;
    end
  endtask

  int bn, sn;

  initial begin
    reset = 1'b1; E_start = 1'b0; E_md_op = 3'd0; E_src_a = 0; E_src_b = 0; D_md_use = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, stall_md}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    issue(3'd1, 32'hFFFFFFFD, 32'd5, bn, sn);
    check("mult_busy_cycles", bn, 5);
    check("mult_stall_cycles", sn, 0);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFF1);

    issue(3'd2, 32'hFFFFFFFF, 32'd2, bn, sn);
    check("multu_busy_cycles", bn, 5);
    check("multu_hi", hi, 32'h00000001);
    check("multu_lo", lo, 32'hFFFFFFFE);

    issue(3'd6, 32'hDEADBEEF, 32'd0, bn, sn);
    check("mtlo_busy_cycles", bn, 0);
    check("mtlo_lo", lo, 32'hDEADBEEF);
    check("mtlo_hi_kept", hi, 32'h00000001);

    issue(3'd3, 32'hFFFFFFF9, 32'd2, bn, sn);
    check("div_busy_cycles", bn, 10);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);

    issue(3'd3, 32'h80000000, 32'hFFFFFFFF, bn, sn);
    check("div_ovf_lo", lo, 32'h80000000);
    check("div_ovf_hi", hi, 32'h00000000);

    issue(3'd5, 32'h11, 32'd0, bn, sn);
    issue(3'd6, 32'h22, 32'd0, bn, sn);
    issue(3'd4, 32'd9, 32'd0, bn, sn);
    check("divu0_busy_cycles", bn, 10);
    check("divu0_hi", hi, 32'h11);
    check("divu0_lo", lo, 32'h22);

    D_md_use = 1'b1;
    issue(3'd3, 32'd100, 32'd7, bn, sn);
    check("div_stall_cycles", sn, 11);
    check("div7_lo", lo, 32'd14);
    check("div7_hi", hi, 32'd2);
    D_md_use = 1'b0;
    issue(3'd3, 32'd100, 32'd7, bn, sn);
    check("div_nouse_stall_cycles", sn, 0);

    // Asynchronous reset in the middle of a divide.
    D_md_use = 1'b1;
    @(posedge clk); #1;
    E_start = 1'b1; E_md_op = 3'd3; E_src_a = 32'd50; E_src_b = 32'd3;
    @(posedge clk); #1;
    E_start = 1'b0; E_md_op = 3'd0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_stall", {31'd0, stall_md}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    D_md_use = 1'b0;
    issue(3'd5, 32'h1234, 32'd0, bn, sn);
    check("post_rst_hi", hi, 32'h1234);
    check("post_rst_lo", lo, 32'd0);

    // Randomized commands, including ones offered while busy.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      E_start  = ($urandom_range(0, 2) != 0);
      E_md_op  = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: E_src_a = 32'h80000000;
        1: E_src_a = $urandom_range(0, 20);
        default: E_src_a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: E_src_b = 32'd0;
        1: E_src_b = 32'hFFFFFFFF;
        2: E_src_b = $urandom_range(1, 9);
        default: E_src_b = $urandom;
      endcase
      D_md_use = ($urandom_range(0, 1) != 0);
    end
    @(posedge clk); #1;
    E_start = 1'b0; E_md_op = 3'd0;
    repeat (20) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
